// File: rtl/srl_seq_shifter_if.sv
// Start/done handshake bundle for the multi-cycle right shifter.
// The master issues requests and reads results; the slave is the shifter.
interface srl_seq_shifter_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = 5
);
  logic             start;
  logic             arith;
  logic [WIDTH-1:0] A;
  logic [SHW-1:0]   shamt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dalja;
  logic             shout;

  modport master (
    output start, arith, A, shamt,
    input  busy, done, dalja, shout
  );

  modport slave (
    input  start, arith, A, shamt,
    output busy, done, dalja, shout
  );
endinterface

// File: rtl/srl_seq_shifter.sv
// Multi-cycle logical/arithmetic right shifter, one bit position per clock.
// Result and last shifted-out bit are held until the next accepted start.
module srl_seq_shifter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = 5
) (
  input logic            clk,
  input logic            rst_n,
  srl_seq_shifter_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           r_state;
  state_e           w_state_d;
  logic [WIDTH-1:0] r_work;
  logic             r_fill;
  logic [CW-1:0]    r_count;
  logic             r_shout;
  logic [31:0]      w_shamt_ext;
  logic [CW-1:0]    w_n;

  // Clamp the shift amount so latency never exceeds WIDTH + 1 cycles.
  always_comb begin
    w_shamt_ext = {{(32 - SHW){1'b0}}, bus.shamt};
    w_n         = (w_shamt_ext >= WIDTH) ? CW'(WIDTH) : CW'(w_shamt_ext);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (bus.start) begin
          w_state_d = (w_n == '0) ? StDone : StShift;
        end
      end
      StShift: begin
        if (r_count == CW'(1)) begin
          w_state_d = StDone;
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work  <= '0;
      r_fill  <= 1'b0;
      r_count <= '0;
      r_shout <= 1'b0;
    end else begin
      if (r_state == StIdle && bus.start) begin
        r_work  <= bus.A;
        r_fill  <= bus.arith & bus.A[WIDTH-1];
        r_count <= w_n;
        r_shout <= 1'b0;
      end else if (r_state == StShift) begin
        r_shout <= r_work[0];
        r_work  <= {r_fill, r_work[WIDTH-1:1]};
        r_count <= r_count - CW'(1);
      end
    end
  end

  // dalja tracks the working register, so intermediate values show during shifting.
  always_comb begin
    bus.busy  = (r_state == StShift);
    bus.done  = (r_state == StDone);
    bus.dalja = r_work;
    bus.shout = r_shout;
  end

endmodule

// File: doc/srl_seq_shifter.md
Name: srl_seq_shifter

Overview:
- Multi-cycle right shifter for the 16-bit CPU datapath. It is the right-shift counterpart of the combinational SLL unit.
- Performs logical (SRL) or arithmetic (SRA) right shifts, one bit position per clock.
- Uses a start/done handshake, so the control unit can stall on `busy`.
- The result and the last bit shifted out are held until the next accepted start.

Parameters:
- WIDTH, 16, data width of operand and result.
- SHW, 5, width of the shift-amount field (same encoding as SLL shamt).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- arith  input  1  0 = SRL (zero fill), 1 = SRA (fill with A[WIDTH-1]); captured with start.
- A  input  WIDTH  operand; captured with start.
- shamt  input  SHW  shift amount; captured with start.
- busy  output  1  high while shifting.
- done  output  1  one-cycle pulse; result valid.
- dalja  output  WIDTH  shift result, held until the next accepted start.
- shout  output  1  last bit shifted out of bit 0; 0 if no shift occurred.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE, busy = 0, done = 0, dalja = 0, shout = 0, internal count = 0.
- Reset mid-operation aborts immediately; no done pulse follows.
- States are IDLE, SHIFT and DONE.
- IDLE:
  - On a clock edge with start = 1, capture the operands: working reg = A, fill bit = arith & A[WIDTH-1], count N = min(shamt, WIDTH), shout cleared to 0.
  - If N = 0, go to DONE; otherwise go to SHIFT.
  - start = 0: stay in IDLE.
- SHIFT (busy = 1):
  - Each edge: shout <= reg[0], reg <= {fill, reg[WIDTH-1:1]}, count <= count - 1.
  - On the edge where count = 1, go to DONE.
- DONE:
  - done = 1 and busy = 0 for exactly one cycle; dalja = reg.
  - The next edge returns to IDLE unconditionally.
  - start in DONE is ignored; the requester must re-assert it in IDLE.
- start while in SHIFT or DONE is ignored; operands captured at acceptance are not disturbed by later input changes.
- Latency: with start accepted at edge E0, done is high in the cycle following edge E0+N (N = 0 gives done in the cycle right after E0).
  - Maximum latency is WIDTH + 1 cycles, because shamt is clamped.
- Clamp (shamt ≥ WIDTH):
  - SRL: dalja = 0, shout = 0 after 16 shifts if A[15] = 0, else 1. shout always equals the last bit actually shifted.
  - SRA: dalja = all copies of A[15].
- dalja reflects the working register continuously. The value is only guaranteed correct while done = 1 and afterwards in IDLE; intermediate values are visible during SHIFT.
- Back-to-back: the earliest next start is accepted on the edge after the DONE cycle (IDLE).
- Arithmetic identity:
  - SRL result equals A >> min(shamt, 16).
  - SRA result equals $signed(A) >>> min(shamt, 16) with sign saturation.

Test Plan:
- Reset, then A = 16'd40, shamt = 3, arith = 0, start for 1 cycle -> busy high 3 cycles; done pulses 4 cycles after the start edge; dalja = 16'd5, shout = 0.
- A = 16'h8000, shamt = 4, arith = 1 -> dalja = 16'hF800, shout = 0. The same operands with arith = 0 -> dalja = 16'h0800.
- A = 16'h0003, shamt = 0 -> no busy; done in the first cycle after start; dalja = 16'h0003, shout = 0. Then A = 16'h0003, shamt = 1 -> dalja = 16'h0001, shout = 1.
- A = 16'hFFFF, shamt = 20, arith = 0 -> done after 17 cycles; dalja = 0, shout = 1. Same with arith = 1 -> dalja = 16'hFFFF.
- start A = 16'd100, shamt = 2. While busy, pulse start with A = 16'd7, shamt = 1 -> ignored; result dalja = 16'd25.
- A = 16'd40, shamt = 10, start, then assert rst_n low at cycle 4 -> busy, done, dalja and shout go to 0 without waiting for a clock edge. No done pulse follows; the next start operates normally.
